// File: rtl/ddr_queue_pkg.sv
// Shared state encoding, default burst geometry and counter-width helper for the
// DDR command-queue burst sequencer.
package ddr_queue_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        STRB = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam int BL_MAX_DEF  = 16;
    localparam int CCD_MIN_DEF = 8;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic int clog2_max(input int a, input int b);
        int m;
        m = max2(a, b);
        return ($clog2(m) < 1) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/burst_cntr.sv
// Loadable up-counter with enable, sync clear, runtime terminal-count compare, optional saturation.
// Latency: count/tc update one cycle after the controlling input.
// Backpressure: none; clear beats load beats enable.
module burst_cntr #(
    parameter int W   = 3,
    parameter bit SAT = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] load_val,
    input  logic [W-1:0] limit,
    output logic [W-1:0] cnt,
    output logic         tc
);

    assign tc = (cnt == limit);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && !(SAT && tc)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/burst_queue_ctrl.sv
// Burst sequencer: pops the queue on valid&ready and drives the SerDes strobe window (BURST_CHOP_EN enables bc).
// Latency: accept in cycle t, first strobe cycle at t+1; back-to-back bursts are seamless.
// Backpressure: ready only when idle or once the tCCD spacing from the current burst start has elapsed.
module burst_queue_ctrl
    import ddr_queue_pkg::*;
#(
    parameter int  BL_MAX  = BL_MAX_DEF,
    parameter int  CCD_MIN = CCD_MIN_DEF,
    localparam int CW      = clog2_max(BL_MAX / 2, CCD_MIN)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          valid,
    input  logic          bc,
    output logic          ready,
    output logic          sh_en,
    output logic          serdes_en,
    output logic [CW-1:0] beat_idx,
    output logic          last,
    output logic          busy
);

    localparam int            N_FULL        = BL_MAX / 2;
    localparam logic [CW-1:0] BEAT_LIM_FULL = CW'(N_FULL - 1);
    localparam logic [CW-1:0] CCD_LIM_FULL  = CW'(max2(N_FULL, CCD_MIN) - 1);

    state_t        state;
    logic          fire;
    logic          strb;
    logic          beat_tc;
    logic          ccd_tc;
    logic [CW-1:0] ccd_cnt;
    logic [CW-1:0] beat_lim;
    logic [CW-1:0] ccd_lim;

`ifdef BURST_CHOP_EN
    localparam int            N_CHOP        = BL_MAX / 4;
    localparam logic [CW-1:0] BEAT_LIM_CHOP = CW'(N_CHOP - 1);
    localparam logic [CW-1:0] CCD_LIM_CHOP  = CW'(max2(N_CHOP, CCD_MIN) - 1);

    logic bc_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bc_q <= 1'b0;
        end else if (fire) begin
            bc_q <= bc;
        end
    end

    assign beat_lim = bc_q ? BEAT_LIM_CHOP : BEAT_LIM_FULL;
    assign ccd_lim  = bc_q ? CCD_LIM_CHOP  : CCD_LIM_FULL;
`else
    logic unused_bc;
    assign unused_bc = bc;
    assign beat_lim  = BEAT_LIM_FULL;
    assign ccd_lim   = CCD_LIM_FULL;
`endif

    // ccd_cnt tracks beat_idx during a strobe window, so ccd_tc can only rise on its last cycle
    assign strb  = (state == STRB);
    assign ready = rst & ((state == IDLE) | ccd_tc);
    assign fire  = valid & ready;
    assign sh_en = fire;
    assign last  = serdes_en & beat_tc;

    burst_cntr #(.W(CW), .SAT(1'b0)) u_beat_cntr (
        .clk      (clk),
        .rst      (rst),
        .clr      (~fire & (~strb | beat_tc)),
        .load     (fire),
        .en       (strb),
        .load_val ('0),
        .limit    (beat_lim),
        .cnt      (beat_idx),
        .tc       (beat_tc)
    );

    burst_cntr #(.W(CW), .SAT(1'b1)) u_ccd_cntr (
        .clk      (clk),
        .rst      (rst),
        .clr      (~fire & (state == IDLE)),
        .load     (fire),
        .en       (1'b1),
        .load_val ('0),
        .limit    (ccd_lim),
        .cnt      (ccd_cnt),
        .tc       (ccd_tc)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            serdes_en <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (fire) begin
                        state     <= STRB;
                        serdes_en <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                STRB: begin
                    if (beat_tc && !fire) begin
                        serdes_en <= 1'b0;
                        if (!ccd_tc) begin
                            state <= GAP;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                GAP: begin
                    if (fire) begin
                        state     <= STRB;
                        serdes_en <= 1'b1;
                    end else if (ccd_tc) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    serdes_en <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

    logic unused_ccd_cnt;
    assign unused_ccd_cnt = ^ccd_cnt;

endmodule

// File: tb/tb_burst_queue_ctrl.sv
// Directed vector bench for burst_queue_ctrl at BL_MAX=16, CCD_MIN=8.
module tb_burst_queue_ctrl;

    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          valid = 1'b0;
    logic          bc = 1'b0;
    logic          ready;
    logic          sh_en;
    logic          serdes_en;
    logic [CW-1:0] beat_idx;
    logic          last;
    logic          busy;

    burst_queue_ctrl #(.BL_MAX(16), .CCD_MIN(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .valid     (valid),
        .bc        (bc),
        .ready     (ready),
        .sh_en     (sh_en),
        .serdes_en (serdes_en),
        .beat_idx  (beat_idx),
        .last      (last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic       valid_v;
        logic       bc_v;
        logic       exp_ready;
        logic       exp_sh;
        logic       exp_se;
        logic [2:0] exp_bi;
        logic       exp_last;
        logic       exp_busy;
    } vec_t;

    vec_t vecs[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic add(input string tag, input logic v, input logic b, input logic r, input logic s,
                       input logic e, input int bi, input logic l, input logic bz);
        vec_t x;
        x.tag = tag; x.valid_v = v; x.bc_v = b; x.exp_ready = r; x.exp_sh = s;
        x.exp_se = e; x.exp_bi = 3'(bi); x.exp_last = l; x.exp_busy = bz;
        vecs.push_back(x);
    endtask

    task automatic run_vecs();
        foreach (vecs[i]) begin
            @(negedge clk);
            valid = vecs[i].valid_v;
            bc    = vecs[i].bc_v;
            #1;
            chk({vecs[i].tag, ".ready"},     i, 32'(ready),     32'(vecs[i].exp_ready));
            chk({vecs[i].tag, ".sh_en"},     i, 32'(sh_en),     32'(vecs[i].exp_sh));
            chk({vecs[i].tag, ".serdes_en"}, i, 32'(serdes_en), 32'(vecs[i].exp_se));
            chk({vecs[i].tag, ".beat_idx"},  i, 32'(beat_idx),  32'(vecs[i].exp_bi));
            chk({vecs[i].tag, ".last"},      i, 32'(last),      32'(vecs[i].exp_last));
            chk({vecs[i].tag, ".busy"},      i, 32'(busy),      32'(vecs[i].exp_busy));
        end
        vecs.delete();
    endtask

    // one full-length burst from IDLE, valid pulsed in cycle 0
    task automatic add_single(input string tag, input logic b);
        add(tag, 1, b, 1, 1, 0, 0, 0, 0);
        for (int k = 1; k < 8; k++) add(tag, 0, b, 0, 0, 1, k - 1, 0, 1);
        add(tag, 0, b, 1, 0, 1, 7, 1, 1);
        add(tag, 0, b, 1, 0, 0, 0, 0, 0);
    endtask

    task automatic reset_at(input string tag, input int cyc);
        add(tag, 1, 0, 1, 1, 0, 0, 0, 0);
        for (int k = 1; k < cyc; k++) add(tag, 0, 0, 0, 0, 1, k - 1, 0, 1);
        run_vecs();
        @(negedge clk);
        valid = 1'b0;
        #1;
        chk({tag, ".pre_se"},   cyc, 32'(serdes_en), 32'(1));
        chk({tag, ".pre_bi"},   cyc, 32'(beat_idx),  32'(cyc - 1));
        chk({tag, ".pre_last"}, cyc, 32'(last),      32'(cyc == 8));
        #2;
        rst = 1'b0;
        #1;
        chk({tag, ".rst_se"},   cyc, 32'(serdes_en), 32'(0));
        chk({tag, ".rst_last"}, cyc, 32'(last),      32'(0));
        chk({tag, ".rst_bi"},   cyc, 32'(beat_idx),  32'(0));
        chk({tag, ".rst_busy"}, cyc, 32'(busy),      32'(0));
        valid = 1'b1;
        @(negedge clk);
        #1;
        chk({tag, ".hold_se"},   cyc, 32'(serdes_en), 32'(0));
        chk({tag, ".hold_busy"}, cyc, 32'(busy),      32'(0));
        valid = 1'b0;
        rst   = 1'b1;
        #1;
        chk({tag, ".rel_ready"}, cyc, 32'(ready), 32'(1));
        chk({tag, ".rel_busy"},  cyc, 32'(busy),  32'(0));
    endtask

    initial begin
        rst = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset.serdes_en", 0, 32'(serdes_en), 32'(0));
        chk("reset.beat_idx",  0, 32'(beat_idx),  32'(0));
        chk("reset.last",      0, 32'(last),      32'(0));
        chk("reset.busy",      0, 32'(busy),      32'(0));
        rst = 1'b1;
        #1;
        chk("reset.ready", 0, 32'(ready), 32'(1));

        add_single("single", 0);
        run_vecs();

        // back-to-back full bursts with valid held, starts at cycles 0 and 8
        add("b2b", 1, 0, 1, 1, 0, 0, 0, 0);
        for (int k = 1; k < 8; k++) add("b2b", 1, 0, 0, 0, 1, k - 1, 0, 1);
        add("b2b", 1, 0, 1, 1, 1, 7, 1, 1);
        for (int k = 9; k < 16; k++) add("b2b", 1, 0, 0, 0, 1, k - 9, 0, 1);
        add("b2b", 0, 0, 1, 0, 1, 7, 1, 1);
        add("b2b", 0, 0, 1, 0, 0, 0, 0, 0);
        run_vecs();

`ifdef BURST_CHOP_EN
        // chopped bursts: 4 strobe cycles, GAP until tCCD elapses, restart at cycle 8
        add("chop", 1, 1, 1, 1, 0, 0, 0, 0);
        for (int k = 1; k < 4; k++) add("chop", 1, 1, 0, 0, 1, k - 1, 0, 1);
        add("chop", 1, 1, 0, 0, 1, 3, 1, 1);
        for (int k = 5; k < 8; k++) add("chop", 1, 1, 0, 0, 0, 0, 0, 1);
        add("chop", 1, 1, 1, 1, 0, 0, 0, 1);
        for (int k = 9; k < 12; k++) add("chop", 0, 1, 0, 0, 1, k - 9, 0, 1);
        add("chop", 0, 1, 0, 0, 1, 3, 1, 1);
        for (int k = 13; k < 16; k++) add("chop", 0, 1, 0, 0, 0, 0, 0, 1);
        add("chop", 0, 1, 1, 0, 0, 0, 0, 1);
        add("chop", 0, 1, 1, 0, 0, 0, 0, 0);
        run_vecs();

        // chopped then full; bc toggling while not ready must not matter
        add("mixed", 1, 1, 1, 1, 0, 0, 0, 0);
        for (int k = 1; k < 4; k++) add("mixed", 1, 1'(k % 2), 0, 0, 1, k - 1, 0, 1);
        add("mixed", 1, 0, 0, 0, 1, 3, 1, 1);
        for (int k = 5; k < 8; k++) add("mixed", 1, 1'(k % 2), 0, 0, 0, 0, 0, 1);
        add("mixed", 1, 0, 1, 1, 0, 0, 0, 1);
        for (int k = 9; k < 16; k++) add("mixed", 0, 1'(k % 2), 0, 0, 1, k - 9, 0, 1);
        add("mixed", 0, 1, 1, 0, 1, 7, 1, 1);
        add("mixed", 0, 1, 1, 0, 0, 0, 0, 0);
        run_vecs();
`else
        // bc is ignored: chop request still yields a full burst
        add_single("nochop", 1);
        run_vecs();
`endif

        reset_at("rst_mid", 4);
        add_single("rst_mid_restart", 0);
        run_vecs();

        reset_at("rst_last", 8);
        add_single("rst_last_restart", 0);
        run_vecs();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/burst_queue_ctrl.md
Name: burst_queue_ctrl

Overview:
Parametrised successor of the command-queue burst sequencer in the DDR5 controller datapath. It accepts write-data bursts from the queue through a valid/ready handshake and pulses the queue shift enable on each accept. It then drives the SerDes strobe window for a full or chopped burst. Back-to-back bursts run seamlessly, and a minimum column-to-column spacing (tCCD) is enforced between burst starts.

Parameters:
BL_MAX, 16, full burst length in beats; power of 2, >=4; two beats per clk (DDR), so a full burst is BL_MAX/2 cycles
CCD_MIN, 8, minimum clk cycles between consecutive burst start cycles; >=1
CW, derived localparam, clog2(max(BL_MAX/2, CCD_MIN)), min 1; width of the internal counters and beat_idx

Ports:
clk  in  1  controller clock
rst  in  1  asynchronous active-low reset
valid  in  1  queue head holds a burst
bc  in  1  burst chop for the offered burst (1 = BL_MAX/2 beats); sampled only on accept
ready  out  1  block can accept a burst this cycle
sh_en  out  1  queue shift/pop pulse, = valid & ready
serdes_en  out  1  SerDes strobe window active
beat_idx  out  CW  strobe cycle index within the current burst, 0..N-1
last  out  1  final strobe cycle of the current burst
busy  out  1  state != IDLE

Behaviour:
- Reset: asynchronous, active-low; all state is cleared immediately.
- Reset values: state=IDLE; serdes_en=0, beat_idx=0, last=0, busy=0, and ready=1 once rst deasserts.
- Reset mid-burst aborts the burst with no completion; strobe outputs drop in the same cycle rst falls.
- Handshake: fire = valid & ready. sh_en = fire combinationally. valid may drop at any time without effect.
- On fire, bc is latched into bc_q.
- N = BL_MAX/4 if bc_q, else BL_MAX/2.
- Latency: fire in cycle t gives the first strobe cycle at t+1.
- States: IDLE, STRB, GAP.
- IDLE:
  - ready=1.
  - fire -> STRB, with beat_idx=0 and ccd_cnt=0.
- STRB:
  - serdes_en=1; beat_idx increments each cycle.
  - last=1 when beat_idx==N-1.
  - ccd_cnt increments each cycle, saturating at CCD_MIN-1 or N-1, whichever is larger.
- ready in STRB/GAP = (ccd_cnt >= max(N, CCD_MIN)-1).
- Transitions on the last strobe cycle:
  - fire -> STRB (seamless restart; beat_idx and ccd_cnt reload to 0; new bc_q latched).
  - else if not ready -> GAP.
  - else -> IDLE.
- GAP:
  - serdes_en=0.
  - ccd_cnt keeps counting; when ready: fire -> STRB, else -> IDLE.
- valid is never accepted while a burst's strobe window has more than one cycle left.
- A full burst with CCD_MIN <= BL_MAX/2 never enters GAP.
- Counters never wrap: beat_idx is bounded by N-1 and ccd_cnt saturates.
- beat_idx=0 outside STRB.

Optional Feature:
BURST_CHOP_EN
- Defined: bc is honoured as above.
- Undefined:
  - The bc port remains present but is ignored; bc_q is tied to 0.
  - Every burst is BL_MAX/2 cycles.
  - The chop-length logic is not synthesised.

Decomposition:
- Package ddr_queue_pkg holds:
  - The state encoding (IDLE/STRB/GAP).
  - Default BL_MAX and CCD_MIN constants.
  - A clog2-max helper function for CW.
- Sub-module burst_cntr: a loadable up-counter with enable, synchronous clear, terminal-count compare against a runtime limit, and optional saturation.
- burst_cntr is instantiated twice: once for the beat counter and once for the tCCD counter.

Test Plan:
1. Single burst, BL_MAX=16, CCD_MIN=8, valid pulsed at cycle 0, bc=0 -> sh_en=1 at cycle 0; serdes_en=1 for cycles 1..8; beat_idx counts 0..7; last=1 at cycle 8; IDLE at cycle 9.
2. Back-to-back: valid held high, bc=0 -> fires at cycles 0 and 8; serdes_en continuous over cycles 1..16; beat_idx wraps 7->0 at cycle 9; no GAP cycle.
3. Chopped burst: bc=1, valid held -> strobe cycles 1..4; GAP for cycles 5..8; ready=1 at cycle 8; second start at cycle 9, i.e. 8 cycles after the first start.
4. Mixed lengths: bc=1 then bc=0 with valid held -> second burst is 8 strobe cycles; bc changes while not ready have no effect.
5. Reset: rst=0 at cycle 4 mid-burst -> serdes_en=0 and last=0 in the same cycle; after release, ready=1, state IDLE, and a new valid starts cleanly.
6. BURST_CHOP_EN undefined, bc=1, valid at cycle 0 -> 8 strobe cycles (1..8); ready follows full-burst timing.
